// File: rtl/slc3_mem_pkg.sv
// Shared types and defaults for the SLC-3 memory path: arbiter states,
// requester identity and the default SRAM wait-state count.
package slc3_mem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} arb_state_t;

  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable 4-bit down-counter that times SRAM wait states; it stops at zero
// and flags it so the sequencer knows when the access window closes.
module mem_wait_timer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  // NOTE: sequential state is written with <= so every register samples
  // the pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM between the CPU memory path and the DMA/loader: round-robin
// arbitration, a fixed wait-state access window and a one-cycle acknowledge.
module sram_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              grant_cpu
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  arb_state_t        state, next_state;
  owner_t            owner, last_owner, winner;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              any_req;
  logic              cnt_zero;

  assign any_req = cpu_req | dma_req;

  // On a tie the requester that was not served last takes the SRAM.
  always_comb begin
    if (cpu_req && (!dma_req || last_owner == OWN_DMA)) winner = OWN_CPU;
    else                                                 winner = OWN_DMA;
  end

  mem_wait_timer u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (state == IDLE && any_req),
    .en       (state == ACCESS),
    .load_val (CNT_LOAD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  if (cnt_zero) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every datapath register has a reset value; a reset mid-access must
  // leave clean rdata and a known address, so nothing here is left unreset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      owner      <= OWN_DMA;
      last_owner <= OWN_DMA;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      sram_addr  <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner     <= winner;
          we_q      <= (winner == OWN_CPU) ? cpu_we    : dma_we;
          wdata_q   <= (winner == OWN_CPU) ? cpu_wdata : dma_wdata;
          sram_addr <= (winner == OWN_CPU) ? cpu_addr  : dma_addr;
        end
        ACCESS: if (cnt_zero && !we_q) begin
          if (owner == OWN_CPU) cpu_rdata <= sram_rdata;
          else                  dma_rdata <= sram_rdata;
        end
        ACK:     last_owner <= owner;
        default: ;
      endcase
    end
  end

  // NOTE: all outputs get a default before the case so no path infers a latch.
  always_comb begin
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_wdata = '0;
    grant_cpu  = 1'b0;
    cpu_ack    = 1'b0;
    dma_ack    = 1'b0;
    case (state)
      ACCESS: begin
        sram_oe_n = we_q;
        sram_we_n = ~we_q;
        if (we_q) sram_wdata = wdata_q;
        grant_cpu = (owner == OWN_CPU);
      end
      ACK: begin
        grant_cpu = (owner == OWN_CPU);
        cpu_ack   = (owner == OWN_CPU);
        dma_ack   = (owner == OWN_DMA);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the access rules.
module tb_sram_arbiter;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [15:0] cpu_rdata, dma_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        cpu_ack, dma_ack, sram_oe_n, sram_we_n, grant_cpu;

  always #5 Clk = ~Clk;

  sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(16), .DATA_W(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .grant_cpu(grant_cpu)
  );

  // Behavioural SRAM (low address byte decoded) with a preload port.
  logic [15:0] mem [256];
  logic        pre_en;
  logic [7:0]  pre_a;
  logic [15:0] pre_d;
  always @(posedge Clk) begin
    if (pre_en)          mem[pre_a] <= pre_d;
    else if (!sram_we_n) mem[sram_addr[7:0]] <= sram_wdata;
  end
  assign sram_rdata = mem[sram_addr[7:0]];

  int checks = 0;
  int errors = 0;

  // Transaction model: a grant at edge t_grant gives W strobe cycles, then an
  // ack cycle, then one idle cycle before the next grant can be taken.
  int          e = 0;
  bit          busy = 1'b0;
  int          t_grant = 0;
  bit          m_cpu, m_we;
  logic [15:0] m_addr, m_wdata;
  bit          last_cpu = 1'b0;
  logic [15:0] exp_addr = '0, exp_cpu_rdata = '0, exp_dma_rdata = '0;
  logic [15:0] ref_mem [256];
  bit          exp_cpu_ack, exp_dma_ack;

  int          n_oe_low, n_we_low, n_cpu_ack, n_dma_ack, n_both_ack;
  int          cpu_ack_e, dma_ack_e;
  logic [15:0] w_addr, w_data;
  bit          ack_cpu_q[$];
  bit          ack_grant_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    n_oe_low = 0; n_we_low = 0; n_cpu_ack = 0; n_dma_ack = 0; n_both_ack = 0;
    cpu_ack_e = -1; dma_ack_e = -1; w_addr = '0; w_data = '0;
    ack_cpu_q.delete(); ack_grant_q.delete();
  endtask

  task automatic tick();
    bit r, act;
    int d;
    r = Reset;
    @(posedge Clk);
    e++;
    @(negedge Clk);
    if (r) begin
      busy = 1'b0; last_cpu = 1'b0;
      exp_addr = '0; exp_cpu_rdata = '0; exp_dma_rdata = '0;
    end
    exp_cpu_ack = 1'b0; exp_dma_ack = 1'b0; act = 1'b0;
    if (busy) begin
      d = e - t_grant;
      if (d < W) act = 1'b1;
      else if (d == W) begin
        if (m_cpu) exp_cpu_ack = 1'b1; else exp_dma_ack = 1'b1;
        if (m_we)       ref_mem[m_addr[7:0]] = m_wdata;
        else if (m_cpu) exp_cpu_rdata = ref_mem[m_addr[7:0]];
        else            exp_dma_rdata = ref_mem[m_addr[7:0]];
      end else begin
        busy = 1'b0; last_cpu = m_cpu;
      end
    end
    check("sram_oe_n",  sram_oe_n,  !(act && !m_we));
    check("sram_we_n",  sram_we_n,  !(act && m_we));
    check("sram_wdata", sram_wdata, (act && m_we) ? m_wdata : 16'h0000);
    check("sram_addr",  sram_addr,  exp_addr);
    check("grant_cpu",  grant_cpu,  busy && m_cpu);
    check("cpu_ack",    cpu_ack,    exp_cpu_ack);
    check("dma_ack",    dma_ack,    exp_dma_ack);
    check("cpu_rdata",  cpu_rdata,  exp_cpu_rdata);
    check("dma_rdata",  dma_rdata,  exp_dma_rdata);
    if (!sram_oe_n) n_oe_low++;
    if (!sram_we_n) begin n_we_low++; w_addr = sram_addr; w_data = sram_wdata; end
    if (cpu_ack) begin n_cpu_ack++; cpu_ack_e = e; ack_cpu_q.push_back(1'b1); ack_grant_q.push_back(grant_cpu); end
    if (dma_ack) begin n_dma_ack++; dma_ack_e = e; ack_cpu_q.push_back(1'b0); ack_grant_q.push_back(grant_cpu); end
    if (cpu_ack && dma_ack) n_both_ack++;
  endtask

  // Called once the next-edge inputs are settled; records a grant if one will happen.
  task automatic plan();
    bit win_cpu;
    if (busy || Reset || !(cpu_req || dma_req)) return;
    win_cpu = cpu_req && (!dma_req || !last_cpu);
    busy    = 1'b1;
    t_grant = e + 1;
    m_cpu   = win_cpu;
    m_we    = win_cpu ? cpu_we    : dma_we;
    m_addr  = win_cpu ? cpu_addr  : dma_addr;
    m_wdata = win_cpu ? cpu_wdata : dma_wdata;
    exp_addr = m_addr;
  endtask

  task automatic run(input int n, input bit drop_cpu, input bit drop_dma);
    repeat (n) begin
      tick();
      if (drop_cpu && exp_cpu_ack) cpu_req = 1'b0;
      if (drop_dma && exp_dma_ack) dma_req = 1'b0;
      plan();
    end
  endtask

  task automatic run_acks(input int target, input int budget, input bit drop, input string tag);
    while ((n_cpu_ack + n_dma_ack) < target && budget > 0) begin
      run(1, drop, drop);
      budget--;
    end
    check(tag, (n_cpu_ack + n_dma_ack) >= target, 1'b1);
  endtask

  task automatic rand_cpu();
    cpu_we = 1'($urandom); cpu_addr = {8'($urandom), 4'h0, 4'($urandom)}; cpu_wdata = 16'($urandom);
  endtask

  task automatic rand_dma();
    dma_we = 1'($urandom); dma_addr = {8'($urandom), 4'h0, 4'($urandom)}; dma_wdata = 16'($urandom);
  endtask

  initial begin
    int t0;
    Reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    pre_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pre_a = 8'(i);
      pre_d = (i == 8'h12) ? 16'hBEEF : 16'h0000;
      ref_mem[i] = pre_d;
      @(negedge Clk);
    end
    pre_en = 1'b0;

    // Reset state.
    clear_obs();
    run(2, 1'b0, 1'b0);
    Reset = 1'b0;
    run(2, 1'b0, 1'b0);

    // CPU read alone.
    clear_obs();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0012;
    plan(); t0 = e + 1;
    run_acks(1, 20, 1'b1, "t1_done");
    run(2, 1'b1, 1'b1);
    check("t1_oe_cycles",  n_oe_low, W);
    check("t1_ack_lat",    cpu_ack_e - t0, W);
    check("t1_rdata",      cpu_rdata, 16'hBEEF);
    check("t1_no_dma_ack", n_dma_ack, 0);

    // DMA write alone.
    clear_obs();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0040; dma_wdata = 16'h1234;
    plan();
    run_acks(1, 20, 1'b1, "t2_done");
    run(2, 1'b1, 1'b1);
    check("t2_we_cycles", n_we_low, W);
    check("t2_oe_cycles", n_oe_low, 0);
    check("t2_addr",      w_addr, 16'h0040);
    check("t2_wdata",     w_data, 16'h1234);
    check("t2_ack",       n_dma_ack, 1);
    check("t2_rdata",     dma_rdata, 16'h0000);

    // Both requests high out of reset: CPU first, DMA one access later.
    Reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0012;
    run(1, 1'b0, 1'b0);
    Reset = 1'b0;
    clear_obs();
    plan();
    run_acks(2, 30, 1'b1, "t3_done");
    run(2, 1'b1, 1'b1);
    check("t3_first_cpu",  ack_cpu_q[0], 1'b1);
    check("t3_second_dma", ack_cpu_q[1], 1'b0);
    check("t3_grant0",     ack_grant_q[0], 1'b1);
    check("t3_grant1",     ack_grant_q[1], 1'b0);
    check("t3_ack_gap",    dma_ack_e - cpu_ack_e, W + 2);
    check("t3_cpu_rdata",  cpu_rdata, 16'h1234);
    check("t3_dma_rdata",  dma_rdata, 16'hBEEF);

    // Continuous tie: owners alternate.
    clear_obs();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 16'hA5A5;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0050;
    plan();
    run_acks(4, 40, 1'b0, "t4_done");
    cpu_req = 1'b0; dma_req = 1'b0;
    run(2, 1'b0, 1'b0);
    check("t4_order0", ack_cpu_q[0], 1'b1);
    check("t4_order1", ack_cpu_q[1], 1'b0);
    check("t4_order2", ack_cpu_q[2], 1'b1);
    check("t4_order3", ack_cpu_q[3], 1'b0);
    check("t4_no_overlap", n_both_ack, 0);

    // Reset in the second ACCESS cycle of a CPU read.
    clear_obs();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0012;
    plan();
    run(2, 1'b1, 1'b1);
    Reset = 1'b1; cpu_req = 1'b0;
    run(1, 1'b1, 1'b1);
    check("t5_oe_n",  sram_oe_n, 1'b1);
    check("t5_we_n",  sram_we_n, 1'b1);
    check("t5_ack",   cpu_ack, 1'b0);
    check("t5_rdata", cpu_rdata, 16'h0000);
    Reset = 1'b0;
    run(4, 1'b1, 1'b1);
    check("t5_no_ack_after", n_cpu_ack, 0);

    // Address change after the latch edge is ignored.
    clear_obs();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    plan();
    run(1, 1'b1, 1'b1);
    check("t6_addr_a", sram_addr, 16'h0010);
    cpu_addr = 16'h0020;
    run(1, 1'b1, 1'b1);
    check("t6_addr_b", sram_addr, 16'h0010);
    run(1, 1'b1, 1'b1);
    check("t6_addr_c", sram_addr, 16'h0010);
    check("t6_ack",    cpu_ack, 1'b1);
    run(2, 1'b1, 1'b1);

    // Random traffic against the model.
    clear_obs();
    for (int k = 0; k < 600; k++) begin
      tick();
      if (exp_cpu_ack) begin
        if ($urandom_range(1) == 0) cpu_req = 1'b0; else rand_cpu();
      end else if (!cpu_req && $urandom_range(2) == 0) begin
        cpu_req = 1'b1; rand_cpu();
      end
      if (exp_dma_ack) begin
        if ($urandom_range(1) == 0) dma_req = 1'b0; else rand_dma();
      end else if (!dma_req && $urandom_range(2) == 0) begin
        dma_req = 1'b1; rand_dma();
      end
      plan();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    run(W + 3, 1'b0, 1'b0);
    check("rand_no_overlap", n_both_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer that shares the single physical SRAM between the SLC-3 CPU memory path (MAR/MDR side) and a DMA/program-loader requester. It sits between those requesters and the SRAM pins. It serializes accesses with round-robin fairness, registers address and data for a fixed number of wait-state cycles, and returns read data with a one-cycle acknowledge.

## Interface
- WAIT_CYCLES, 2: SRAM cycles per access; legal range 1..15
- ADDR_W, 16: address width
- DATA_W, 16: data width
- Clk  in  1  system clock, all logic on posedge
- Reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, level
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  registered read data for CPU
- cpu_ack  out  1  one-cycle completion pulse
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same as cpu_* for the DMA requester
- sram_addr  out  ADDR_W  registered SRAM address
- sram_wdata  out  DATA_W  SRAM write data; 0 when not writing
- sram_rdata  in  DATA_W  SRAM read data
- sram_oe_n  out  1  active-low output enable
- sram_we_n  out  1  active-low write enable
- grant_cpu  out  1  1 while the CPU owns the current access (status/LED)

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE:
  - If any req is high, latch the owner, we, addr and wdata from that requester.
  - Load cnt = WAIT_CYCLES-1 and go to ACCESS.
- Arbitration:
  - A single request wins.
  - If both request, the requester not served last wins.
  - last_owner resets to DMA, so CPU wins the first tie.
- ACCESS:
  - sram_addr = latched addr.
  - Read: sram_oe_n = 0, sram_we_n = 1.
  - Write: sram_we_n = 0, sram_oe_n = 1, sram_wdata = latched wdata.
  - Decrement cnt each cycle.
  - When cnt == 0: capture sram_rdata into the owner's rdata register (reads only), then go to ACK.
- ACK:
  - Pulse the owner's ack for exactly one cycle.
  - SRAM strobes are deasserted (both 1).
  - Update last_owner and return to IDLE.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until ack.
  - Changes made after the IDLE latch cycle are ignored.
  - A req still high in the IDLE cycle after ACK is treated as a new request.
- rdata:
  - Holds its value until the next read completes for that requester.
  - Writes leave rdata unchanged.
  - The other requester's rdata is never disturbed.
- Output values:
  - grant_cpu is valid in ACCESS and ACK; 0 in IDLE.
  - sram_addr holds its last value in IDLE and ACK.

## Timing
- Reset values:
  - state = IDLE, last_owner = DMA, cnt = 0.
  - cpu_rdata = dma_rdata = 0; cpu_ack = dma_ack = 0.
  - sram_oe_n = sram_we_n = 1; sram_addr = 0; sram_wdata = 0; grant_cpu = 0.
- Latency:
  - req sampled high in IDLE at edge T.
  - Strobes are active for cycles T+1 .. T+WAIT_CYCLES.
  - ack is high in cycle T+WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- Back-to-back ties alternate owners.
- A lone requester may be served consecutively.
- Reset mid-ACCESS or mid-ACK:
  - Next edge returns to IDLE with strobes high.
  - No ack is issued; rdata is cleared to 0.
- sram_we_n is never low while sram_oe_n is low.
- Both strobes are never low in IDLE.

## Structure
- Package slc3_mem_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, ACK} arb_state_t.
  - typedef enum logic {OWN_CPU, OWN_DMA} owner_t.
  - Default WAIT_CYCLES constant.
- One sub-module, mem_wait_timer: loadable 4-bit down-counter with load, enable and a zero flag.
- The FSM, latches and output registers stay in sram_arbiter.

## Test plan
- CPU read alone, WAIT_CYCLES=2, cpu_addr=0x0012, sram_rdata=0xBEEF during ACCESS:
  - sram_oe_n low for 2 cycles, cpu_ack in cycle 3 after the request edge.
  - cpu_rdata = 0xBEEF, dma_ack stays 0.
- DMA write alone, dma_addr=0x0040, dma_wdata=0x1234:
  - sram_we_n low 2 cycles with sram_addr=0x0040, sram_wdata=0x1234, sram_oe_n high.
  - dma_ack pulse; dma_rdata unchanged.
- Both requests high from reset, each held until its ack:
  - CPU served first, then DMA.
  - Acks separated by 4 cycles; grant_cpu 1 then 0.
- Both requests continuously reasserted for 4 accesses:
  - Grant order CPU, DMA, CPU, DMA.
  - No ack ever overlaps another.
- Reset asserted in the second ACCESS cycle of a CPU read:
  - Next cycle IDLE, strobes high, no cpu_ack, cpu_rdata = 0.
- cpu_addr changed from 0x0010 to 0x0020 mid-ACCESS:
  - sram_addr stays 0x0010 until the access completes.
